// File: rtl/param_seq_detect.sv
// Runtime-programmable serial pattern detector with registered match pulse and saturating match counter.
// Optional sticky hit flag enabled by defining SEQ_DETECT_STICKY_EN.
module param_seq_detect #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1101,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           din,
  input  logic                           din_valid,
  input  logic                           cfg_we,
  input  logic [MAX_LEN-1:0]             cfg_pattern,
  input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
  input  logic                           cfg_overlap,
  input  logic                           cnt_clr,
  output logic                           y,
  output logic [CNT_W-1:0]               match_cnt,
  output logic                           sticky_hit
);

  localparam int                LEN_W     = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;
  logic [MAX_LEN-1:0] hist_reg;
  logic [LEN_W-1:0]   fill_reg;
  logic               y_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [MAX_LEN-1:0] nh;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_p1;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   cfg_len_eff;
  logic               hit;
  logic               unused_hist_msb;

  // The oldest history bit only matters for the shift, never for a compare.
  assign unused_hist_msb = hist_reg[MAX_LEN-1];

  assign nh = {hist_reg[MAX_LEN-2:0], din};

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign len_mask[gi] = (LEN_W'(gi) < len_reg);
    end
  endgenerate

  assign fill_p1   = {1'b0, fill_reg} + {{LEN_W{1'b0}}, 1'b1};
  assign fill_next = (fill_reg == MAX_LEN_V) ? fill_reg : fill_p1[LEN_W-1:0];

  assign hit = !cfg_we && din_valid
             && (fill_p1 >= {1'b0, len_reg})
             && (((nh ^ pattern_reg) & len_mask) == '0);

  always_comb begin
    cfg_len_eff = cfg_len;
    if (cfg_len == '0)
      cfg_len_eff = LEN_W'(1);
    else if (cfg_len > MAX_LEN_V)
      cfg_len_eff = MAX_LEN_V;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pattern_reg <= DEF_PATTERN;
      len_reg     <= LEN_W'(DEF_LEN);
      overlap_reg <= DEF_OVERLAP;
      hist_reg    <= '0;
      fill_reg    <= '0;
      y_reg       <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      y_reg <= hit;
      if (cfg_we) begin
        pattern_reg <= cfg_pattern;
        len_reg     <= cfg_len_eff;
        overlap_reg <= cfg_overlap;
        hist_reg    <= '0;
        fill_reg    <= '0;
      end else if (din_valid) begin
        hist_reg <= nh;
        // Non-overlap mode restarts the fill count so the next match needs len fresh bits.
        fill_reg <= (hit && !overlap_reg) ? '0 : fill_next;
      end
      if (cnt_clr)
        cnt_reg <= hit ? CNT_W'(1) : '0;
      else if (hit && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign y         = y_reg;
  assign match_cnt = cnt_reg;

`ifdef SEQ_DETECT_STICKY_EN
  logic sticky_reg;

  always_ff @(posedge clk) begin
    if (!rst)
      sticky_reg <= 1'b0;
    else if (hit)
      sticky_reg <= 1'b1;
    else if (cnt_clr)
      sticky_reg <= 1'b0;
  end

  assign sticky_hit = sticky_reg;
`else
  assign sticky_hit = 1'b0;
`endif

endmodule

// File: tb/tb_param_seq_detect.sv
// Table-driven bench for param_seq_detect with a scoreboard queue of expected outputs.
module tb_param_seq_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       y;
  logic [7:0] match_cnt;
  logic       sticky_hit;
  logic       y3;
  logic [2:0] match_cnt3;
  logic       sticky_hit3;

  always #5 clk = ~clk;

  param_seq_detect dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y), .match_cnt(match_cnt), .sticky_hit(sticky_hit)
  );

  param_seq_detect #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y3), .match_cnt(match_cnt3), .sticky_hit(sticky_hit3)
  );

  typedef struct {
    logic       we, dv, d, clr;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       ey;
  } vec_t;

  typedef struct {
    logic       y;
    logic [7:0] c8;
    logic [2:0] c3;
    logic       st;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  logic [7:0] m8  = '0;
  logic [2:0] m3  = '0;
  logic       mst = 1'b0;

  function automatic void add(input logic we, dv, d, clr, input logic [7:0] pat,
                              input logic [3:0] len, input logic ovl, input logic ey);
    vec_t v;
    v.we = we; v.dv = dv; v.d = d; v.clr = clr;
    v.pat = pat; v.len = len; v.ovl = ovl; v.ey = ey;
    tbl.push_back(v);
  endfunction

  function automatic void add_bit(input logic d, input logic ey);
    add(1'b0, 1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, ey);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (txn %0d): got %0h, expected %0h", name, n_txn, act, exp);
    end
  endtask

  task automatic step(input logic we, dv, d, clr, input logic [7:0] pat,
                      input logic [3:0] len, input logic ovl, input logic ey, input logic rn);
    exp_t e;
    @(negedge clk);
    rst = rn; cfg_we = we; din_valid = dv; din = d; cnt_clr = clr;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    if (!rn) begin
      m8 = '0; m3 = '0; mst = 1'b0;
    end else begin
      if (clr) begin
        m8 = ey ? 8'd1 : 8'd0;
        m3 = ey ? 3'd1 : 3'd0;
      end else if (ey) begin
        if (m8 != 8'hff) m8 = m8 + 8'd1;
        if (m3 != 3'd7)  m3 = m3 + 3'd1;
      end
      mst = ey ? 1'b1 : (clr ? 1'b0 : mst);
    end
    e.y = rn ? ey : 1'b0;
    e.c8 = m8;
    e.c3 = m3;
`ifdef SEQ_DETECT_STICKY_EN
    e.st = mst;
`else
    e.st = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_txn++;
    $display("txn %0d rst=%b we=%b dv=%b d=%b clr=%b | y=%b cnt=%0d cnt3=%0d sticky=%b | exp y=%b cnt=%0d",
             n_txn, rn, we, dv, d, clr, y, match_cnt, match_cnt3, sticky_hit, e.y, e.c8);
    chk("y", {7'b0, y}, {7'b0, e.y});
    chk("match_cnt", match_cnt, e.c8);
    chk("y_cnt3", {7'b0, y3}, {7'b0, e.y});
    chk("match_cnt_cnt3", {5'b0, match_cnt3}, {5'b0, e.c3});
    chk("sticky_hit", {7'b0, sticky_hit}, {7'b0, e.st});
  endtask

  task automatic bit_in(input logic d, input logic ey);
    step(1'b0, 1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, ey, 1'b1);
  endtask

  task automatic idle(input logic clr);
    step(1'b0, 1'b0, 1'b0, clr, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; din = 1'b0; din_valid = 1'b0; cfg_we = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cnt_clr = 1'b0;

    // Default pattern 1101
    add_bit(1,0); add_bit(1,0); add_bit(0,0); add_bit(1,1); add_bit(0,0); add_bit(0,0);
    // Overlap with defaults
    add_bit(1,0); add_bit(1,0); add_bit(0,0); add_bit(1,1);
    add_bit(1,0); add_bit(0,0); add_bit(1,1);
    // 111, overlap on
    add(1,0,0,0,8'b111,4'd3,1,0);
    add_bit(1,0); add_bit(1,0); add_bit(1,1); add_bit(1,1); add_bit(1,1); add_bit(1,1);
    // 111, overlap off
    add(1,0,0,0,8'b111,4'd3,0,0);
    add_bit(1,0); add_bit(1,0); add_bit(1,1); add_bit(1,0); add_bit(1,0); add_bit(1,1);
    // din_valid gaps
    add(1,0,0,0,8'b1101,4'd4,1,0);
    add_bit(1,0); add_bit(1,0);
    add(0,0,0,0,8'h00,4'd0,0,0); add(0,0,0,0,8'h00,4'd0,0,0); add(0,0,0,0,8'h00,4'd0,0,0);
    add_bit(0,0); add_bit(1,1);
    // Config mid-stream clears history
    add_bit(1,0); add_bit(1,0); add_bit(0,0);
    add(1,0,0,0,8'b01,4'd2,1,0);
    add_bit(1,0); add_bit(0,0); add_bit(1,1);
    // cfg_len=0 acts as 1; din ignored during cfg write
    add(1,1,1,0,8'b1,4'd0,1,0);
    add_bit(0,0); add_bit(1,1); add_bit(1,1); add_bit(0,0);
    // cfg_len above MAX_LEN clamps to 8
    add(1,0,0,0,8'b10110011,4'd15,1,0);
    add_bit(1,0); add_bit(0,0); add_bit(1,0); add_bit(1,0);
    add_bit(0,0); add_bit(0,0); add_bit(1,0); add_bit(1,1);
    // cnt_clr coinciding with a match, then alone
    add(1,0,0,0,8'b1101,4'd4,1,0);
    add_bit(1,0); add_bit(1,0); add_bit(0,0);
    add(0,1,1,1,8'h00,4'd0,0,1);
    add(0,0,0,1,8'h00,4'd0,0,0);

    step(0,0,0,0,8'h00,4'd0,0,0,1'b0);
    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].we, tbl[i].dv, tbl[i].d, tbl[i].clr, tbl[i].pat, tbl[i].len,
           tbl[i].ovl, tbl[i].ey, 1'b1);

    // Reset mid-pattern while cfg_we is asserted
    step(1,0,0,0,8'b111,4'd3,1,0,1'b1);
    bit_in(1,0); bit_in(1,0);
    step(1,1,1,0,8'b1,4'd1,1,0,1'b0);
    bit_in(1,0); bit_in(1,0); bit_in(0,0); bit_in(1,1);

    // Counter saturation: 9 matches
    idle(1'b1);
    for (int g = 0; g < 9; g++) begin
      bit_in(1,0); bit_in(1,0); bit_in(0,0); bit_in(1,1);
    end
    chk("cnt3_saturated", {5'b0, match_cnt3}, 8'd7);
    chk("cnt8_nine", match_cnt, 8'd9);

    // Sticky hold then clear
    idle(1'b1);
    bit_in(1,0); bit_in(1,0); bit_in(0,0); bit_in(1,1);
    for (int k = 0; k < 10; k++) idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/param_seq_detect.md
Name: param_seq_detect

Overview:
- Parametrised, runtime-programmable serial pattern detector; next generation of the fixed 4-bit Mealy detector in the FSM problem set.
- Pattern (1..MAX_LEN bits), length and overlap mode are loaded via a config port.
- Adds input qualification (din_valid), a saturating match counter, and a registered one-cycle match pulse.
- Sits between a serial bit source and downstream control/stat logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2); LEN_W = $clog2(MAX_LEN+1) is a localparam.
- CNT_W, 8, match counter width.
- DEF_PATTERN, 8'b0000_1101, pattern loaded at reset (MAX_LEN bits).
- DEF_LEN, 4, pattern length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset. One clock; reset is synchronous and active-low (rst==0 at posedge resets).
- din  in  1  serial data bit.
- din_valid  in  1  din sampled only when 1.
- cfg_we  in  1  load cfg_* this cycle.
- cfg_pattern  in  MAX_LEN  new pattern. Bit [len-1] is the first bit received; bit [0] is the last.
- cfg_len  in  LEN_W  new length.
- cfg_overlap  in  1  1 = overlapping matches allowed.
- cnt_clr  in  1  clear match_cnt.
- y  out  1  one-cycle match pulse (registered).
- match_cnt  out  CNT_W  saturating match count.
- sticky_hit  out  1  see Optional Feature.

Behaviour:
- **Reset** (rst==0 at posedge, overrides all other inputs):
  - hist=0, fill=0, y=0, match_cnt=0, sticky_hit=0.
  - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
- **Internal state:**
  - hist[MAX_LEN-1:0] holds the last accepted bits; the newest bit is in hist[0].
  - fill counts valid history bits and saturates at MAX_LEN.
- **y default:** y is 0 every cycle unless a match fires. It is never held for more than one cycle.
- **Config write** (cfg_we=1, rst=1):
  - Load pattern, len and overlap.
  - cfg_len=0 is stored as 1; cfg_len>MAX_LEN is stored as MAX_LEN.
  - Clear hist and fill. y=0.
  - din is ignored this cycle, even if din_valid=1.
  - match_cnt is unaffected.
- **Idle** (cfg_we=0, din_valid=0): hist and fill hold; y=0.
- **Accept** (cfg_we=0, din_valid=1):
  - nh = {hist[MAX_LEN-2:0], din}.
  - match = (fill+1 >= len) && (nh[len-1:0] == pattern[len-1:0]).
  - hist <= nh; fill <= min(fill+1, MAX_LEN).
  - On match:
    - y <= 1.
    - match_cnt increments, saturating at 2^CNT_W-1.
    - If overlap=0, fill <= 0 (hist still shifts), so the next match needs len fresh bits.
- **Latency:** y is high for exactly the one cycle following the posedge that samples the final pattern bit (Mealy decision, registered output). Same timing as the existing detector.
- **cnt_clr:**
  - match_cnt <= 0.
  - If a match occurs in the same cycle, match_cnt <= 1 (clear, then count).
  - cnt_clr does not affect y or hist.
- **Reset mid-pattern:** partial history is discarded and config reverts to defaults. The next match requires a full pattern after rst returns to 1.

Optional Feature:
- Macro SEQ_DETECT_STICKY_EN.
- **Defined:**
  - sticky_hit is set on any match and held until cnt_clr=1 or reset.
  - Set and clear in the same cycle: set wins, so sticky_hit=1.
- **Undefined:** sticky_hit is tied to 0 and no flop is inferred. The port is always present.

Test Plan:
- **Default pattern:** reset, then valid bits 1,1,0,1 -> y=1 for exactly one cycle after the 4th bit; match_cnt=1. Then 0,0 -> y stays 0.
- **Overlap mode:**
  - Defaults (overlap=1), bits 1,1,0,1,1,0,1 -> pulses after bits 4 and 7; match_cnt=2.
  - cfg pattern=8'b111, len=3, overlap=1; bits 1×6 -> 4 pulses.
  - Same config with overlap=0 -> 2 pulses (after bits 3 and 6).
- **din_valid gaps:** bits 1,1, then three cycles with din_valid=0 and din=0, then 0,1 -> single pulse after the final 1; no pulse during the gaps.
- **Config mid-stream:** after 1,1,0, cfg_we with pattern=8'b01, len=2 -> history cleared. A following 1 gives no pulse; a further 0,1 gives a pulse. cfg_len=0 behaves as len=1.
- **Counter:**
  - With CNT_W=3, 9 matches -> match_cnt=7 (saturated).
  - cnt_clr in the same cycle as a match -> match_cnt=1.
  - Reset with rst=0 while cfg_we=1 -> defaults restored; bits 1,1,0,1 match.
- **Sticky:** with SEQ_DETECT_STICKY_EN, one match -> sticky_hit=1 and held for 10 cycles; cnt_clr -> 0. Without the macro, sticky_hit=0 throughout.
